// File: rtl/vga_rx_pkg.sv
// Shared types and helpers for the VGA timing recovery block.
// Build option VGA_RX_SYNC_EN adds input synchronizers in vga_rx_edge.
package vga_rx_pkg;

    localparam int CW_DEF = 12;

    // bit positions of the sync/blank inputs inside the edge bundle
    localparam int IX_HS = 0;
    localparam int IX_VS = 1;
    localparam int IX_HB = 2;
    localparam int IX_VB = 3;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        VERIFY,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [CW_DEF-1:0] line_len;
        logic [CW_DEF-1:0] frame_lines;
        logic [CW_DEF-1:0] act_w;
        logic [CW_DEF-1:0] act_h;
    } geo_t;

    function automatic logic [CW_DEF-1:0] sat_inc(
        input logic [CW_DEF-1:0] v
    );
        return (&v) ? v : v + CW_DEF'(1);
    endfunction

    // a saturated field never counts as a match
    function automatic logic geo_same(
        input geo_t a,
        input geo_t b
    );
        logic sat;
        sat = (&a.line_len) | (&a.frame_lines)
            | (&a.act_w) | (&a.act_h);
        return (a == b) && !sat;
    endfunction

endpackage

// File: rtl/vga_rx_edge.sv
// Optional 2-flop synchronizer plus previous-sample edge detection.
// VGA_RX_SYNC_EN inserts the synchronizer; otherwise inputs are used directly.
module vga_rx_edge #(
    parameter int           N    = 4,
    parameter logic [N-1:0] IDLE = '1
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [N-1:0] din,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] smp;
    logic [N-1:0] prev;

`ifdef VGA_RX_SYNC_EN
    logic [N-1:0] meta;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            meta <= IDLE;
            smp  <= IDLE;
        end else begin
            meta <= din;
            smp  <= meta;
        end
    end
`else
    assign smp = din;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) prev <= IDLE;
        else          prev <= smp;
    end

    assign level = smp;
    assign rise  = smp & ~prev;
    assign fall  = ~smp & prev;

endmodule

// File: rtl/vga_timing_recover.sv
// Recovers x/y/de and raster geometry from hsync/vsync/hblank/vblank.
// Define VGA_RX_SYNC_EN to synchronize asynchronous inputs (3-cycle latency).
module vga_timing_recover
    import vga_rx_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int TIMEOUT = 4095
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          hblank,
    input  logic          vblank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          frame_start,
    output logic [CW-1:0] line_len,
    output logic [CW-1:0] frame_lines,
    output logic [CW-1:0] act_w,
    output logic [CW-1:0] act_h,
    output logic          locked,
    output logic          lock_lost
);

    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;

    vga_rx_edge #(
        .N    (4),
        .IDLE (4'b1111)
    ) u_edge (
        .aclk    (aclk),
        .aresetn (aresetn),
        .din     ({vblank, hblank, vsync, hsync}),
        .level   (lvl),
        .rise    (rise),
        .fall    (fall)
    );

    logic hs_f, vs_f, hb_f, hb_r, vb_f;
    logic hb_lo, vb_lo;

    assign hs_f  = fall[IX_HS];
    assign vs_f  = fall[IX_VS];
    assign hb_f  = fall[IX_HB];
    assign hb_r  = rise[IX_HB];
    assign vb_f  = fall[IX_VB];
    assign hb_lo = ~lvl[IX_HB];
    assign vb_lo = ~lvl[IX_VB];

    logic unused_edges;
    assign unused_edges = ^{lvl[IX_HS], lvl[IX_VS],
                            rise[IX_HS], rise[IX_VS],
                            rise[IX_VB]};

    state_t        state, state_n;
    geo_t          golden, gold_n, g_new;
    logic [CW-1:0] lc, ac, fl, ah, tmo;
    logic [CW-1:0] fl_now, ah_now;
    logic          ln_ok, fr_ok;
    logic          line_bad, ac_nz, tmo_hit;

    always_comb begin
        ac_nz  = (ac != '0);
        fl_now = hs_f ? sat_inc(fl) : fl;
        ah_now = (hb_r && vb_lo) ? sat_inc(ah) : ah;

        // a coincident hsync edge closes this frame's last line first
        g_new.line_len    = (hs_f && ln_ok) ? lc : line_len;
        g_new.frame_lines = fl_now;
        g_new.act_w       = (hs_f && ln_ok && ac_nz) ? ac : act_w;
        g_new.act_h       = ah_now;

        line_bad = 1'b0;
        if (hs_f && ln_ok) begin
            line_bad = (lc != golden.line_len) || (&lc);
            if (ac_nz)
                line_bad = line_bad
                         || (ac != golden.act_w) || (&ac);
        end

        tmo_hit = !hs_f && (sat_inc(tmo) >= TMO);
    end

    always_comb begin
        state_n = state;
        gold_n  = golden;
        unique case (state)
            SEARCH: begin
                if (vs_f) state_n = MEASURE;
            end
            MEASURE: begin
                if (vs_f) begin
                    state_n = VERIFY;
                    gold_n  = g_new;
                end
            end
            VERIFY: begin
                if (vs_f) begin
                    state_n = geo_same(g_new, golden)
                            ? LOCKED : MEASURE;
                    gold_n  = g_new;
                end
            end
            LOCKED: begin
                if (line_bad) state_n = SEARCH;
                if (vs_f && !geo_same(g_new, golden))
                    state_n = SEARCH;
            end
            default: state_n = SEARCH;
        endcase
        if (tmo_hit) state_n = SEARCH;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= SEARCH;
            golden      <= '0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            act_w       <= '0;
            act_h       <= '0;
            lc          <= '0;
            ac          <= '0;
            fl          <= '0;
            ah          <= '0;
            tmo         <= '0;
            ln_ok       <= 1'b0;
            fr_ok       <= 1'b0;
        end else begin
            state     <= state_n;
            golden    <= gold_n;
            locked    <= (state_n == LOCKED);
            lock_lost <= (state == LOCKED) && (state_n != LOCKED);

            if (hb_f)       x <= '0;
            else if (hb_lo) x <= sat_inc(x);

            if (vb_f)                y <= '0;
            else if (hb_r && vb_lo)  y <= sat_inc(y);

            de          <= hb_lo & vb_lo;
            frame_start <= vs_f;

            tmo <= hs_f ? '0 : sat_inc(tmo);

            if (hs_f) begin
                lc    <= CW'(1);
                ac    <= hb_lo ? CW'(1) : '0;
                ln_ok <= 1'b1;
                if (ln_ok) begin
                    line_len <= lc;
                    if (ac_nz) act_w <= ac;
                end
            end else begin
                lc <= sat_inc(lc);
                if (hb_lo) ac <= sat_inc(ac);
            end

            if (vs_f) begin
                fl    <= '0;
                ah    <= '0;
                fr_ok <= 1'b1;
                if (fr_ok) begin
                    frame_lines <= fl_now;
                    act_h       <= ah_now;
                end
            end else begin
                fl <= fl_now;
                ah <= ah_now;
            end
        end
    end

endmodule
